clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Upstream time-setting front end for the 16x2 LCD date/time clock.
- Debounces three raw push-buttons (mode, up, down) and runs an edit FSM over the six fields: year, month, day, hour, min, sec.
- Presents the edited values with a one-cycle load strobe. The clock counter then overwrites its year/month/day/hour/min/sec registers.
- Provides editing, field and blink outputs so the LCD writer can hold the clock and blink the selected field.

Parameters:
- CNT1MS, 100_000: clk cycles per 1 ms tick (100 MHz).
- DEBOUNCE_MS, 20: consecutive ms a synchronised button level must stay changed before it is accepted.
- TIMEOUT_MS, 10_000: ms without any accepted press in EDIT before the edit is aborted.
- BLINK_MS, 250: ms per half-period of blink.

Ports:
- clk  in  1  system clock, 100 MHz.
- resetn  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw button, active-high, asynchronous.
- btn_up  in  1  raw button, active-high, asynchronous.
- btn_down  in  1  raw button, active-high, asynchronous.
- cur_year  in  12  live year from the clock counter.
- cur_month  in  5  live month, 1..12.
- cur_day  in  8  live day.
- cur_hour  in  5  live hour, 0..23.
- cur_min  in  6  live minute, 0..59.
- cur_sec  in  6  live second, 0..59.
- set_year  out  12  edited year.
- set_month  out  5  edited month.
- set_day  out  8  edited day.
- set_hour  out  5  edited hour.
- set_min  out  6  edited minute.
- set_sec  out  6  edited second.
- load  out  1  one-clk strobe: commit set_* into the clock counter.
- editing  out  1  high in EDIT; the clock counter holds while high.
- field  out  3  selected field: 0=year, 1=month, 2=day, 3=hour, 4=min, 5=sec.
- blink  out  1  cursor blink, valid only while editing.

Behaviour:
- Clock and reset: clk is the only clock. resetn is asynchronous and active-low.
- Reset values: set_year=2024, set_month=1, set_day=1, set_hour/min/sec=0, load=0, editing=0, field=0, blink=0. All counters clear and FSM=IDLE.
- Reset mid-edit discards the edit and never produces load.
- 1 ms tick: internal counter 0..CNT1MS-1 drives a one-cycle tick1ms pulse.
- Input conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - The counter increments on tick1ms while the synchronised level differs from the stable level, and clears when they are equal.
  - At DEBOUNCE_MS the stable level takes the new value.
  - A press event is a one-clk pulse on the rising edge of the stable level. Release generates no event.
  - No auto-repeat.
- FSM state IDLE:
  - set_* hold their last values; editing=0; field=0; blink=0.
  - A mode event snapshots cur_* into set_*. Year is clamped to 2000..2099; day is clamped to days_in_month(month).
  - Then field=0, editing=1, timeout and blink counters clear, and the FSM goes to EDIT. All outputs update on the clk after the event.
  - up/down events in IDLE are ignored.
- FSM state EDIT, mode event:
  - field<5: field increments.
  - field==5: load=1 for exactly one clk, then editing=0, field=0, FSM goes to IDLE. set_* stay stable through and after load.
- FSM state EDIT, up event: selected field +1 with wrap.
  - year 2099->2000.
  - month 12->1.
  - day days_in_month(set_month)->1.
  - hour 23->0.
  - min and sec 59->0.
- FSM state EDIT, down event: selected field -1 with mirror wrap (2000->2099, 1->12, 1->dim, 0->23, 0->59).
- Month change clamps day: if set_day > days_in_month(new month), set_day becomes that maximum in the same clk. days_in_month matches the clock counter: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28 for Feb; 31 for any other value.
- Simultaneous events in the same clk:
  - mode with up or down: mode acts, up/down are dropped.
  - up with down: both are dropped.
- Timeout: any accepted event in EDIT clears the timeout counter. Reaching TIMEOUT_MS returns to IDLE with editing=0 and no load; set_* keep the partially edited values.
- blink: in EDIT, blink=1 on entry and toggles every BLINK_MS ms. It is forced to 0 in IDLE.
- Latency: raw edge -> press event = 2 clk + DEBOUNCE_MS ms (±1 tick). Press event -> output change = 1 clk.

Test Plan:
- Release resetn with buttons idle -> set_*=2024/01/01 00:00:00, load=0, editing=0, blink=0. Assert resetn low mid-EDIT -> same values with no load pulse.
- Bench with CNT1MS=10 and DEBOUNCE_MS=4. Bounce btn_up 5x at 2 ms spacing, then hold it -> exactly one up event. A 3 ms glitch on btn_mode -> no event.
- cur=2031/01/31 23:59:58. Press mode, then up on field 1 -> set_month=2, set_day=28.
- Continue mode x5 to field 5 -> one-clk load with set_*=2031/02/28 23:59:58, then editing=0.
- Enter EDIT with cur_year=2099. Press up -> 2000. Press down -> 2099. On the hour field at 0, press down -> 23.
- In EDIT, press nothing for TIMEOUT_MS -> editing falls, load never asserts, field=0. Observe blink toggling every BLINK_MS ms before the timeout.
- Assert up and down debounced in the same clk -> field value unchanged. Assert mode and up together on field 0 -> field=1, year unchanged.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting front end: debounces mode/up/down buttons and runs the edit FSM
// that produces set_* values plus a one-clock load strobe for the clock counter.
module clock_set_ctrl #(
    parameter int CNT1MS      = 100_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_MS  = 10_000,
    parameter int BLINK_MS    = 250
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [11:0] cur_year,
    input  logic [4:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    output logic [11:0] set_year,
    output logic [4:0]  set_month,
    output logic [7:0]  set_day,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_min,
    output logic [5:0]  set_sec,
    output logic        load,
    output logic        editing,
    output logic [2:0]  field,
    output logic        blink
);
    localparam int TW = $clog2(CNT1MS + 1);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int OW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_LOAD} state_t;

    function automatic logic [7:0] days_in_month(input logic [4:0] m);
        case (m)
            5'd4, 5'd6, 5'd9, 5'd11: days_in_month = 8'd30;
            5'd2:                    days_in_month = 8'd28;
            default:                 days_in_month = 8'd31;
        endcase
    endfunction

    // 1 ms tick
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick1ms;

    assign tick1ms = (tick_cnt_q == TW'(CNT1MS - 1));

    always_comb begin
        tick_cnt_d = tick1ms ? '0 : tick_cnt_q + 1'b1;
    end

    // Button conditioning; bit order is {down, up, mode}
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    stable_q, stable_d, stable_dly_q;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [2:0]    press;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick1ms) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
                    stable_d[i] = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_q & ~stable_dly_q;

    logic ev_mode, ev_inc, ev_dec, ev_any;
    assign ev_mode = press[0];
    assign ev_inc  = press[1] & ~press[2] & ~press[0];
    assign ev_dec  = press[2] & ~press[1] & ~press[0];
    assign ev_any  = |press;

    // Edit FSM and output registers
    state_t        state_q, state_d;
    logic [11:0]   set_year_q, set_year_d;
    logic [4:0]    set_month_q, set_month_d;
    logic [7:0]    set_day_q, set_day_d;
    logic [4:0]    set_hour_q, set_hour_d;
    logic [5:0]    set_min_q, set_min_d;
    logic [5:0]    set_sec_q, set_sec_d;
    logic          load_q, load_d;
    logic          editing_q, editing_d;
    logic [2:0]    field_q, field_d;
    logic          blink_q, blink_d;
    logic [OW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] bl_cnt_q, bl_cnt_d;
    logic [4:0]    month_new;
    logic [7:0]    dim_cur, dim_new, dim_snap;

    assign dim_cur  = days_in_month(set_month_q);
    assign dim_snap = days_in_month(cur_month);

    always_comb begin
        state_d     = state_q;
        set_year_d  = set_year_q;
        set_month_d = set_month_q;
        set_day_d   = set_day_q;
        set_hour_d  = set_hour_q;
        set_min_d   = set_min_q;
        set_sec_d   = set_sec_q;
        load_d      = 1'b0;
        editing_d   = editing_q;
        field_d     = field_q;
        blink_d     = blink_q;
        to_cnt_d    = to_cnt_q;
        bl_cnt_d    = bl_cnt_q;
        month_new   = set_month_q;
        dim_new     = dim_cur;

        case (state_q)
            ST_IDLE: begin
                editing_d = 1'b0;
                field_d   = 3'd0;
                blink_d   = 1'b0;
                if (ev_mode) begin
                    if (cur_year < 12'd2000)      set_year_d = 12'd2000;
                    else if (cur_year > 12'd2099) set_year_d = 12'd2099;
                    else                          set_year_d = cur_year;
                    set_month_d = cur_month;
                    set_day_d   = (cur_day > dim_snap) ? dim_snap : cur_day;
                    set_hour_d  = cur_hour;
                    set_min_d   = cur_min;
                    set_sec_d   = cur_sec;
                    editing_d   = 1'b1;
                    blink_d     = 1'b1;
                    to_cnt_d    = '0;
                    bl_cnt_d    = '0;
                    state_d     = ST_EDIT;
                end
            end

            ST_EDIT: begin
                editing_d = 1'b1;
                if (tick1ms) begin
                    if (bl_cnt_q == BW'(BLINK_MS - 1)) begin
                        bl_cnt_d = '0;
                        blink_d  = ~blink_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + 1'b1;
                    end
                end

                if (ev_any) begin
                    to_cnt_d = '0;
                end else if (tick1ms) begin
                    if (to_cnt_q == OW'(TIMEOUT_MS - 1)) begin
                        // Abort keeps the partial edit but never commits it
                        to_cnt_d  = '0;
                        editing_d = 1'b0;
                        field_d   = 3'd0;
                        blink_d   = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end

                if (ev_mode) begin
                    if (field_q == 3'd5) begin
                        load_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        field_d = field_q + 3'd1;
                    end
                end else if (ev_inc || ev_dec) begin
                    case (field_q)
                        3'd0: begin
                            if (ev_inc) set_year_d = (set_year_q >= 12'd2099) ? 12'd2000 : set_year_q + 12'd1;
                            else        set_year_d = (set_year_q <= 12'd2000) ? 12'd2099 : set_year_q - 12'd1;
                        end
                        3'd1: begin
                            if (ev_inc) month_new = (set_month_q >= 5'd12) ? 5'd1 : set_month_q + 5'd1;
                            else        month_new = (set_month_q <= 5'd1) ? 5'd12 : set_month_q - 5'd1;
                            dim_new     = days_in_month(month_new);
                            set_month_d = month_new;
                            if (set_day_q > dim_new) set_day_d = dim_new;
                        end
                        3'd2: begin
                            if (ev_inc) set_day_d = (set_day_q >= dim_cur) ? 8'd1 : set_day_q + 8'd1;
                            else        set_day_d = (set_day_q <= 8'd1) ? dim_cur : set_day_q - 8'd1;
                        end
                        3'd3: begin
                            if (ev_inc) set_hour_d = (set_hour_q >= 5'd23) ? 5'd0 : set_hour_q + 5'd1;
                            else        set_hour_d = (set_hour_q == 5'd0) ? 5'd23 : set_hour_q - 5'd1;
                        end
                        3'd4: begin
                            if (ev_inc) set_min_d = (set_min_q >= 6'd59) ? 6'd0 : set_min_q + 6'd1;
                            else        set_min_d = (set_min_q == 6'd0) ? 6'd59 : set_min_q - 6'd1;
                        end
                        3'd5: begin
                            if (ev_inc) set_sec_d = (set_sec_q >= 6'd59) ? 6'd0 : set_sec_q + 6'd1;
                            else        set_sec_d = (set_sec_q == 6'd0) ? 6'd59 : set_sec_q - 6'd1;
                        end
                        default: ;
                    endcase
                end
            end

            // load is high for this single cycle while editing still holds the counter
            ST_LOAD: begin
                editing_d = 1'b0;
                field_d   = 3'd0;
                blink_d   = 1'b0;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            state_q      <= ST_IDLE;
            set_year_q   <= 12'd2024;
            set_month_q  <= 5'd1;
            set_day_q    <= 8'd1;
            set_hour_q   <= '0;
            set_min_q    <= '0;
            set_sec_q    <= '0;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
            field_q      <= '0;
            blink_q      <= 1'b0;
            to_cnt_q     <= '0;
            bl_cnt_q     <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            sync1_q      <= {btn_down, btn_up, btn_mode};
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q      <= state_d;
            set_year_q   <= set_year_d;
            set_month_q  <= set_month_d;
            set_day_q    <= set_day_d;
            set_hour_q   <= set_hour_d;
            set_min_q    <= set_min_d;
            set_sec_q    <= set_sec_d;
            load_q       <= load_d;
            editing_q    <= editing_d;
            field_q      <= field_d;
            blink_q      <= blink_d;
            to_cnt_q     <= to_cnt_d;
            bl_cnt_q     <= bl_cnt_d;
        end
    end

    assign set_year  = set_year_q;
    assign set_month = set_month_q;
    assign set_day   = set_day_q;
    assign set_hour  = set_hour_q;
    assign set_min   = set_min_q;
    assign set_sec   = set_sec_q;
    assign load      = load_q;
    assign editing   = editing_q;
    assign field     = field_q;
    assign blink     = blink_q;
endmodule
